mux1hot_rr_arbiter: RTL and testbench

Round-robin arbiter that produces the registered one-hot select vector driving a downstream `Mux1hot` instance. It takes `INPUTS` request lines and holds a single grant until the consumer acknowledges the transfer. It then rotates priority so every requester is served fairly. Its `gnt` output connects directly to the mux `sel` port; `gnt_id` gives the binary index for logging and for downstream bookkeeping.

---
 rtl/mux1hot_rr_arbiter.sv | 93 +++++++++
 tb/tb_mux1hot_rr_arbiter.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/mux1hot_rr_arbiter.sv
// Round-robin arbiter producing the registered one-hot select for a Mux1hot instance.
// Optional build macro MUX1HOT_ARB_LOCK_EN adds a lock input that holds a grant across multi-beat transfers.
module mux1hot_rr_arbiter #(
    parameter  int INPUTS = 4,
    localparam int ID_W   = $clog2(INPUTS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [INPUTS-1:0] req,
    input  logic              ack,
`ifdef MUX1HOT_ARB_LOCK_EN
    input  logic              lock,
`endif
    output logic [INPUTS-1:0] gnt,
    output logic [ID_W-1:0]   gnt_id,
    output logic              valid
);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t            state;
    logic [ID_W-1:0]   last;
    logic [ID_W-1:0]   base_ptr;
    logic              win_found;
    logic [ID_W-1:0]   win_id;
    logic [INPUTS-1:0] win_onehot;
    logic              advance;

`ifdef MUX1HOT_ARB_LOCK_EN
    assign advance = ack & ~lock;
`else
    assign advance = ack;
`endif

    // On an advancing ack the pointer becomes the current grant in the same edge,
    // so the scan starts just above gnt_id rather than the stale pointer.
    assign base_ptr = (state == GRANT) ? gnt_id : last;

    always_comb begin
        int idx;
        win_found  = 1'b0;
        win_id     = '0;
        win_onehot = '0;
        idx        = 0;
        for (int i = 1; i <= INPUTS; i++) begin
            idx = (int'(base_ptr) + i) % INPUTS;
            if (!win_found && req[idx]) begin
                win_found       = 1'b1;
                win_id          = ID_W'(idx);
                win_onehot[idx] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            gnt    <= '0;
            gnt_id <= '0;
            valid  <= 1'b0;
            last   <= ID_W'(INPUTS - 1);
        end else begin
            case (state)
                IDLE: begin
                    if (win_found) begin
                        gnt    <= win_onehot;
                        gnt_id <= win_id;
                        valid  <= 1'b1;
                        state  <= GRANT;
                    end
                end
                GRANT: begin
                    if (advance) begin
                        last <= gnt_id;
                        if (win_found) begin
                            gnt    <= win_onehot;
                            gnt_id <= win_id;
                        end else begin
                            gnt   <= '0;
                            valid <= 1'b0;
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mux1hot_rr_arbiter.sv
// Directed-vector bench for mux1hot_rr_arbiter with INPUTS=4.
// Build with MUX1HOT_ARB_LOCK_EN defined to also exercise the lock input.
module tb_mux1hot_rr_arbiter;

    localparam int INPUTS = 4;
    localparam int ID_W   = $clog2(INPUTS);

    logic              clk;
    logic              rst;
    logic [INPUTS-1:0] req;
    logic              ack;
`ifdef MUX1HOT_ARB_LOCK_EN
    logic              lock;
`endif
    logic [INPUTS-1:0] gnt;
    logic [ID_W-1:0]   gnt_id;
    logic              valid;

    int assertionCount = 0;
    int failureCount   = 0;

    mux1hot_rr_arbiter #(.INPUTS(INPUTS)) dut (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .ack    (ack),
`ifdef MUX1HOT_ARB_LOCK_EN
        .lock   (lock),
`endif
        .gnt    (gnt),
        .gnt_id (gnt_id),
        .valid  (valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertionCount++;
        if (observed !== expected) begin
            failureCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Inputs change 1 time unit after the edge; outputs are sampled at that same point.
    task automatic applyStimulus(input logic r, input logic [INPUTS-1:0] q, input logic a);
        rst = r;
        req = q;
        ack = a;
        @(posedge clk);
        #1;
    endtask

    task automatic checkGrant(input string tag, input logic [INPUTS-1:0] expGnt,
                              input logic [ID_W-1:0] expId, input logic expValid);
        checkOutput({tag, ".gnt"}, 32'(gnt), 32'(expGnt));
        checkOutput({tag, ".valid"}, 32'(valid), 32'(expValid));
        if (expValid) checkOutput({tag, ".gnt_id"}, 32'(gnt_id), 32'(expId));
    endtask

    initial begin
        logic [INPUTS-1:0] rotGnt [5];
        logic [ID_W-1:0]   rotId  [5];
        rotGnt = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        rotId  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

        rst = 1'b1;
        req = '0;
        ack = 1'b0;
`ifdef MUX1HOT_ARB_LOCK_EN
        lock = 1'b0;
`endif
        #1;

        // Reset and first grant
        applyStimulus(1'b1, 4'b0000, 1'b0);
        applyStimulus(1'b1, 4'b0000, 1'b0);
        checkGrant("reset", 4'b0000, 2'd0, 1'b0);
        checkOutput("reset.gnt_id", 32'(gnt_id), 32'd0);
        applyStimulus(1'b0, 4'b0001, 1'b0);
        checkGrant("first", 4'b0001, 2'd0, 1'b1);
        applyStimulus(1'b0, 4'b0000, 1'b1);
        checkGrant("drain0", 4'b0000, 2'd0, 1'b0);

        // Rotation from a freshly reset pointer
        applyStimulus(1'b1, 4'b0000, 1'b0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 4'b1111, 1'b1);
            checkGrant($sformatf("rot%0d", i), rotGnt[i], rotId[i], 1'b1);
        end

        // Hold until ack; a dropped request does not disturb the grant
        applyStimulus(1'b0, 4'b0110, 1'b1);
        checkGrant("hold.start", 4'b0010, 2'd1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 4'b0110, 1'b0);
            checkGrant($sformatf("hold%0d", i), 4'b0010, 2'd1, 1'b1);
        end
        applyStimulus(1'b0, 4'b0100, 1'b0);
        checkGrant("hold.drop", 4'b0010, 2'd1, 1'b1);
        applyStimulus(1'b0, 4'b0100, 1'b1);
        checkGrant("hold.ack", 4'b0100, 2'd2, 1'b1);

        // Reset wins over ack mid-grant, pointer returns to top
        applyStimulus(1'b1, 4'b0100, 1'b1);
        checkGrant("midrst", 4'b0000, 2'd0, 1'b0);
        checkOutput("midrst.gnt_id", 32'(gnt_id), 32'd0);
        applyStimulus(1'b0, 4'b1111, 1'b0);
        checkGrant("postrst", 4'b0001, 2'd0, 1'b1);

        // Drain to idle and bubble back; ack while idle is ignored
        applyStimulus(1'b0, 4'b1000, 1'b1);
        checkGrant("drain.sel", 4'b1000, 2'd3, 1'b1);
        applyStimulus(1'b0, 4'b0000, 1'b1);
        checkGrant("drain.idle", 4'b0000, 2'd0, 1'b0);
        applyStimulus(1'b0, 4'b0000, 1'b1);
        checkGrant("idle.ack", 4'b0000, 2'd0, 1'b0);
        applyStimulus(1'b0, 4'b0001, 1'b0);
        checkGrant("bubble", 4'b0001, 2'd0, 1'b1);

        // Sole requester regrants to itself
        applyStimulus(1'b0, 4'b0001, 1'b1);
        checkGrant("sole", 4'b0001, 2'd0, 1'b1);

`ifdef MUX1HOT_ARB_LOCK_EN
        lock = 1'b1;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 4'b0011, 1'b1);
            checkGrant($sformatf("lock%0d", i), 4'b0001, 2'd0, 1'b1);
        end
        lock = 1'b0;
        applyStimulus(1'b0, 4'b0011, 1'b1);
        checkGrant("unlock", 4'b0010, 2'd1, 1'b1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", assertionCount, failureCount);
        $finish;
    end

endmodule
